// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: fixed/rotating priority, HRQ/HLDA hold handshake, one-hot DACK until transferDone.
// Optional HLDA wait timeout is compiled in with DMA_ARB_HLDA_TIMEOUT_EN.
module dma_priority_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int HLDA_TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              rotatePriority,
  input  logic              controllerDisable,
  input  logic              HLDA,
  input  logic              transferDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [1:0]        activeChannel,
  output logic              programCondition,
  output logic              hldaTimeout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_RELEASE} state_e;

  state_e            state_q;
  logic [1:0]        ptr_q;
  logic [1:0]        ptr_eff;
  logic [1:0]        win_idx;
  logic [NUM_CH-1:0] elig;
  logic              any_elig;

  assign elig     = DREQ & ~maskReg & {NUM_CH{~controllerDisable}};
  assign any_elig = |elig;
  assign ptr_eff  = rotatePriority ? ptr_q : 2'd0;

  // Scan from lowest priority upward so the last hit is the highest-priority eligible channel.
  always_comb begin
    win_idx = ptr_eff;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[ptr_eff + 2'(i)]) win_idx = ptr_eff + 2'(i);
    end
  end

`ifdef DMA_ARB_HLDA_TIMEOUT_EN
  localparam int TO_W = $clog2(HLDA_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_flag_q;
  assign hldaTimeout = to_flag_q;
`else
  assign hldaTimeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q          <= S_IDLE;
      HRQ              <= 1'b0;
      DACK             <= '0;
      grantValid       <= 1'b0;
      activeChannel    <= 2'd0;
      programCondition <= 1'b1;
      ptr_q            <= 2'd0;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
      to_cnt_q         <= '0;
      to_flag_q        <= 1'b0;
`endif
    end else begin
      if (!rotatePriority) ptr_q <= 2'd0;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (any_elig && !HLDA) begin
            state_q          <= S_REQ;
            HRQ              <= 1'b1;
            programCondition <= 1'b0;
          end else begin
            programCondition <= !HLDA;
          end
        end
        S_REQ: begin
          if (!any_elig) begin
            HRQ <= 1'b0;
            if (HLDA) begin
              state_q <= S_RELEASE;
            end else begin
              state_q          <= S_IDLE;
              programCondition <= 1'b1;
            end
          end else if (HLDA) begin
            state_q       <= S_GRANT;
            activeChannel <= win_idx;
            DACK          <= {{(NUM_CH-1){1'b0}}, 1'b1} << win_idx;
            grantValid    <= 1'b1;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
          end else if (to_cnt_q == TO_W'(HLDA_TIMEOUT - 1)) begin
            state_q          <= S_IDLE;
            HRQ              <= 1'b0;
            programCondition <= 1'b1;
            to_flag_q        <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
          end
        end
        S_GRANT: begin
          if (transferDone) begin
            state_q    <= S_RELEASE;
            HRQ        <= 1'b0;
            DACK       <= '0;
            grantValid <= 1'b0;
            // Served channel drops to lowest priority for the next round.
            if (rotatePriority) ptr_q <= activeChannel + 2'd1;
          end
        end
        S_RELEASE: begin
          if (!HLDA) begin
            state_q          <= S_IDLE;
            programCondition <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed stimulus, per-cycle reference model compare, literal spot checks.
module tb_dma_priority_arbiter;
  localparam int HLDA_TIMEOUT = 16;

  logic       CLK = 1'b0;
  logic       RESET, HLDA, rotatePriority, controllerDisable, transferDone;
  logic [3:0] DREQ, maskReg, DACK;
  logic       HRQ, grantValid, programCondition, hldaTimeout;
  logic [1:0] activeChannel;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  dma_priority_arbiter #(.NUM_CH(4), .HLDA_TIMEOUT(HLDA_TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg),
    .rotatePriority(rotatePriority), .controllerDisable(controllerDisable),
    .HLDA(HLDA), .transferDone(transferDone), .HRQ(HRQ), .DACK(DACK),
    .grantValid(grantValid), .activeChannel(activeChannel),
    .programCondition(programCondition), .hldaTimeout(hldaTimeout)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase of the bus-hold sequence plus the served channel and priority base.
  typedef enum int {M_IDLE, M_REQ, M_GRANT, M_REL} mph_e;
  mph_e ph;
  int   m_ch, m_ptr, m_cnt;
  bit   m_to, m_pc;

  function automatic int pick(input logic [3:0] e, input int base);
    for (int k = 0; k < 4; k++) if (e[(base + k) % 4]) return (base + k) % 4;
    return -1;
  endfunction

  always @(posedge CLK) begin
    logic [3:0] e;
    int   w, n_ch, n_ptr, n_cnt;
    mph_e n_ph;
    bit   n_to;
    e     = controllerDisable ? 4'b0000 : (DREQ & ~maskReg);
    w     = pick(e, rotatePriority ? m_ptr : 0);
    n_ph  = ph; n_ch = m_ch; n_ptr = rotatePriority ? m_ptr : 0; n_cnt = m_cnt; n_to = m_to;
    if (RESET) begin
      ph <= M_IDLE; m_ch <= 0; m_ptr <= 0; m_cnt <= 0; m_to <= 1'b0; m_pc <= 1'b1;
    end else begin
      case (ph)
        M_IDLE:  if (w >= 0 && !HLDA) n_ph = M_REQ;
        M_REQ: begin
          if (w < 0) n_ph = HLDA ? M_REL : M_IDLE;
          else if (HLDA) begin n_ph = M_GRANT; n_ch = w; end
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
          else begin
            n_cnt++;
            if (n_cnt == HLDA_TIMEOUT) begin n_ph = M_IDLE; n_to = 1'b1; end
          end
`endif
          if (n_ph != M_REQ) n_cnt = 0;
        end
        M_GRANT: if (transferDone) begin
          n_ph = M_REL;
          if (rotatePriority) n_ptr = (m_ch + 1) % 4;
        end
        M_REL:   if (!HLDA) n_ph = M_IDLE;
        default: n_ph = M_IDLE;
      endcase
      ph <= n_ph; m_ch <= n_ch; m_ptr <= n_ptr; m_cnt <= n_cnt; m_to <= n_to;
      m_pc <= (n_ph == M_IDLE) && !HLDA;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model HRQ", HRQ, (ph == M_REQ || ph == M_GRANT));
      chk("model DACK", DACK, (ph == M_GRANT) ? (4'b0001 << m_ch) : 4'b0000);
      chk("model grantValid", grantValid, ph == M_GRANT);
      chk("model activeChannel", activeChannel, m_ch[1:0]);
      chk("model programCondition", programCondition, m_pc);
      chk("model hldaTimeout", hldaTimeout, m_to);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One full service from IDLE with an eligible request pending.
  task automatic serve(input int wait_c, input logic [3:0] exp, input logic [1:0] exp_ch, input string nm);
    tick(1);
    chk({nm, " hrq"}, HRQ, 1);
    chk({nm, " pc"}, programCondition, 0);
    if (wait_c > 0) tick(wait_c);
    HLDA = 1'b1;
    tick(1);
    chk({nm, " dack"}, DACK, exp);
    chk({nm, " ch"}, activeChannel, exp_ch);
    tick(1);
    transferDone = 1'b1;
    tick(1);
    transferDone = 1'b0;
    chk({nm, " release"}, {HRQ, grantValid, DACK}, 0);
    HLDA = 1'b0;
    tick(1);
    chk({nm, " idle pc"}, programCondition, 1);
  endtask

  logic [3:0] rot_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    RESET = 1'b1; DREQ = '0; maskReg = '0; rotatePriority = 1'b0;
    controllerDisable = 1'b0; HLDA = 1'b0; transferDone = 1'b0;
    tick(2);
    chk_en = 1'b1;
    chk("reset state", {HRQ, grantValid, programCondition, hldaTimeout, DACK}, 8'b0010_0000);
    chk("reset ch", activeChannel, 0);
    RESET = 1'b0;

    // Fixed priority: ch1 first, then ch3 once ch1 has gone away.
    DREQ = 4'b1010;
    serve(1, 4'b0010, 2'd1, "fixed ch1");
    DREQ = 4'b1000;
    serve(1, 4'b1000, 2'd3, "fixed ch3");

    // Rotating priority with all requests held.
    rotatePriority = 1'b1;
    DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) serve(0, rot_exp[i], 2'(i % 4), "rotate");
    rotatePriority = 1'b0;
    DREQ = 4'b0000;
    tick(1);

    // Higher-priority request arriving before HLDA wins.
    DREQ = 4'b0100;
    tick(2);
    DREQ = 4'b0101;
    tick(1);
    HLDA = 1'b1;
    tick(1);
    chk("late ch0 dack", DACK, 4'b0001);
    transferDone = 1'b1; tick(1); transferDone = 1'b0;
    DREQ = 4'b0000; HLDA = 1'b0; tick(1);

    // Masked and disabled requests never raise HRQ.
    maskReg = 4'b0001; DREQ = 4'b0001;
    tick(4);
    chk("masked hrq/pc", {HRQ, programCondition}, 2'b01);
    maskReg = 4'b0000; controllerDisable = 1'b1;
    tick(4);
    chk("disabled hrq/pc", {HRQ, programCondition}, 2'b01);
    controllerDisable = 1'b0; DREQ = 4'b0000;
    tick(1);

    // Stray HLDA in IDLE: no request, not programmable.
    HLDA = 1'b1; DREQ = 4'b0001;
    tick(3);
    chk("stray hlda", {HRQ, programCondition}, 2'b00);
    HLDA = 1'b0; DREQ = 4'b0000;
    tick(1);

    // HLDA arrives as all requests vanish: withdraw without grant.
    DREQ = 4'b0010;
    tick(1);
    DREQ = 4'b0000; HLDA = 1'b1;
    tick(1);
    chk("withdraw", {HRQ, grantValid, DACK}, 0);
    HLDA = 1'b0;
    tick(1);
    chk("withdraw idle pc", programCondition, 1);
    transferDone = 1'b1; tick(1); transferDone = 1'b0;

    // DREQ drop mid-service keeps DACK until transferDone.
    DREQ = 4'b0010;
    tick(1);
    HLDA = 1'b1;
    tick(1);
    DREQ = 4'b0000;
    tick(3);
    chk("held dack", DACK, 4'b0010);
    transferDone = 1'b1; tick(1); transferDone = 1'b0;
    HLDA = 1'b0; tick(1);

    // Reset mid-grant with HLDA still high.
    DREQ = 4'b0100;
    tick(1);
    HLDA = 1'b1;
    tick(1);
    chk("pre-reset dack", DACK, 4'b0100);
    RESET = 1'b1;
    tick(1);
    chk("mid reset", {HRQ, programCondition, DACK}, 6'b01_0000);
    RESET = 1'b0; HLDA = 1'b0; DREQ = 4'b0000;
    tick(2);

    DREQ = 4'b0001;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
    tick(1);
    tick(HLDA_TIMEOUT - 1);
    chk("timeout last req hrq", HRQ, 1);
    tick(1);
    chk("timeout drop", {HRQ, hldaTimeout, programCondition}, 3'b011);
    DREQ = 4'b0000;
    tick(3);
    chk("timeout sticky", hldaTimeout, 1);
    RESET = 1'b1; tick(1); RESET = 1'b0;
    chk("timeout cleared", hldaTimeout, 0);
`else
    tick(30);
    chk("no timeout hrq", {HRQ, hldaTimeout}, 2'b10);
    HLDA = 1'b1; tick(1);
    chk("late grant", DACK, 4'b0001);
    transferDone = 1'b1; tick(1); transferDone = 1'b0;
    DREQ = 4'b0000; HLDA = 1'b0; tick(1);
`endif
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
